// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receiver blocks (sampler, start/stop
// checkers, deserializer).
//   PRESC_8/16/32  : legal oversampling ratios
//   RX_IDLE        : idle level of the serial line
//   eff_prescale() : maps a raw PRESCALE value onto a legal ratio
package uart_rx_pkg;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic RX_IDLE = 1'b1;

  // Unsupported ratios fall back to 8 so the counters always terminate.
  function automatic int unsigned eff_prescale(input int unsigned presc);
    if (presc == PRESC_8 || presc == PRESC_16 || presc == PRESC_32) begin
      return presc;
    end
    return PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_edge_bit_counter.sv
// edge_bit_counter
// Oversampling tick counter and bit index counter for the UART receiver.
//   CLK, RST  : clock, synchronous active-high reset
//   cnt_en    : counting enable; low clears both counters on the next edge
//   p_eff     : effective oversampling ratio (8, 16 or 32)
//   edge_cnt  : tick within the current bit
//   bit_cnt   : bit index within the frame (start bit = 0), wraps
//   bit_done  : high during the terminal tick of each bit while counting
module edge_bit_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cnt_en,
  input  logic [PRESCALE_W-1:0] p_eff,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] p_last;
  logic                  terminal;

  // ">=" rather than "==" so a ratio lowered mid-frame cannot strand the
  // counter above the new terminal value.
  always_comb begin
    p_last   = p_eff - PRESCALE_W'(1);
    terminal = (edge_cnt >= p_last);
    bit_done = cnt_en & terminal;
  end

  always_ff @(posedge CLK) begin
    if (RST || !cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (terminal) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Oversampling front end of the UART receiver: counts ticks and bits, takes
// three samples around mid-bit and publishes their majority vote.
//   CLK, RST     : clock, synchronous active-high reset
//   RX_IN        : serial line, synchronised to CLK, idle high
//   PRESCALE     : oversampling ratio (8/16/32, anything else acts as 8)
//   cnt_en       : enables edge/bit counting (from RX FSM)
//   samp_en      : enables sample capture and vote (from RX FSM)
//   edge_cnt     : tick within the current bit
//   bit_cnt      : bit index within the frame
//   bit_done     : pulse on the last tick of each bit
//   sample_data  : majority-voted bit value, held between updates
//   sample_valid : one-cycle pulse when sample_data is updated
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  cnt_en,
  input  logic                  samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sample_data,
  output logic                  sample_valid
);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] cap0_tick;
  logic [PRESCALE_W-1:0] cap1_tick;
  logic [PRESCALE_W-1:0] cap2_tick;
  logic [PRESCALE_W-1:0] vote_tick;
  logic                  s0;
  logic                  s1;
  logic                  s2;

  always_comb begin
    p_eff     = PRESCALE_W'(eff_prescale(32'(PRESCALE)));
    half      = p_eff >> 1;
    cap0_tick = half - PRESCALE_W'(1);
    cap1_tick = half;
    cap2_tick = half + PRESCALE_W'(1);
    vote_tick = half + PRESCALE_W'(2);
  end

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edge_bit_counter (
    .CLK      (CLK),
    .RST      (RST),
    .cnt_en   (cnt_en),
    .p_eff    (p_eff),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  // Stage: three shadow samples around mid-bit, then vote one tick after the
  // last one. Decoded from edge_cnt alone, so a vote coinciding with cnt_en
  // falling still completes on that edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0           <= RX_IDLE;
      s1           <= RX_IDLE;
      s2           <= RX_IDLE;
      sample_data  <= RX_IDLE;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (samp_en) begin
        if (edge_cnt == cap0_tick) s0 <= RX_IN;
        if (edge_cnt == cap1_tick) s1 <= RX_IN;
        if (edge_cnt == cap2_tick) s2 <= RX_IN;
        if (edge_cnt == vote_tick) begin
          sample_data  <= majority3(s0, s1, s2);
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] PRESCALE;
  logic          cnt_en;
  logic          samp_en;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_done;
  logic          sample_data;
  logic          sample_valid;

  int checks = 0;
  int errors = 0;
  logic sb[$];

  uart_rx_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PRESCALE     (PRESCALE),
    .cnt_en       (cnt_en),
    .samp_en      (samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .bit_done     (bit_done),
    .sample_data  (sample_data),
    .sample_valid (sample_valid)
  );

  always #5 CLK = ~CLK;

  // Drive the inputs for one cycle just after the edge, then settle so the
  // outputs observed belong to that same cycle.
  task automatic step(input logic rx, input logic ce, input logic se, input logic rst);
    @(posedge CLK);
    #1;
    RX_IN = rx; cnt_en = ce; samp_en = se; RST = rst;
    #1;
  endtask

  task automatic run_frame(input string name, input int p, input int nbits,
                           input logic [31:0] bits, input int glitch_bit, input int glitch_e);
    int   nvalid;
    int   ndone;
    logic rx;
    logic expv;
    nvalid = 0;
    ndone  = 0;
    for (int b = 0; b < nbits; b++) begin
      sb.push_back(bits[b]);
      for (int e = 0; e < p; e++) begin
        rx = bits[b];
        if (b == glitch_bit && e == glitch_e) rx = ~rx;
        step(rx, 1'b1, 1'b1, 1'b0);
        checks++;
        if (edge_cnt !== PW'(e)) begin
          errors++;
          $display("FAIL %s edge_cnt bit %0d: got %0d expected %0d", name, b, edge_cnt, e);
        end
        if (e == 0) begin
          checks++;
          if (bit_cnt !== BW'(b)) begin
            errors++;
            $display("FAIL %s bit_cnt: got %0d expected %0d", name, bit_cnt, b);
          end
        end
        if (bit_done === 1'b1) begin
          ndone++;
          checks++;
          if (e != p - 1) begin
            errors++;
            $display("FAIL %s bit_done tick: got %0d expected %0d", name, e, p - 1);
          end
        end
        if (sample_valid === 1'b1) begin
          nvalid++;
          checks++;
          if (e != p / 2 + 3) begin
            errors++;
            $display("FAIL %s sample_valid tick: got %0d expected %0d", name, e, p / 2 + 3);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected sample_valid: got pulse expected none", name);
          end else begin
            expv = sb.pop_front();
            if (sample_data !== expv) begin
              errors++;
              $display("FAIL %s sample_data bit %0d: got %b expected %b", name, b, sample_data, expv);
            end
          end
        end
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (edge_cnt !== '0 || bit_cnt !== BW'(nbits)) begin
      errors++;
      $display("FAIL %s end counters: got %0d/%0d expected 0/%0d", name, edge_cnt, bit_cnt, nbits % 16);
    end
    checks++;
    if (nvalid != nbits || sb.size() != 0) begin
      errors++;
      $display("FAIL %s valid count: got %0d expected %0d (pending %0d)", name, nvalid, nbits, sb.size());
      sb.delete();
    end
    checks++;
    if (ndone != nbits) begin
      errors++;
      $display("FAIL %s bit_done count: got %0d expected %0d", name, ndone, nbits);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (edge_cnt !== '0 || bit_cnt !== '0 || bit_done !== 1'b0) begin
      errors++;
      $display("FAIL %s clear: got %0d/%0d/%b expected 0/0/0", name, edge_cnt, bit_cnt, bit_done);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (edge_cnt !== '0) begin
      errors++; $display("FAIL %s edge_cnt: got %0d expected 0", name, edge_cnt);
    end
    checks++;
    if (bit_cnt !== '0) begin
      errors++; $display("FAIL %s bit_cnt: got %0d expected 0", name, bit_cnt);
    end
    checks++;
    if (bit_done !== 1'b0) begin
      errors++; $display("FAIL %s bit_done: got %b expected 0", name, bit_done);
    end
    checks++;
    if (sample_data !== 1'b1) begin
      errors++; $display("FAIL %s sample_data: got %b expected 1", name, sample_data);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL %s sample_valid: got %b expected 0", name, sample_valid);
    end
  endtask

  task automatic test_reset();
    PRESCALE = PW'(8);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_reset_values("reset");
  endtask

  task automatic test_p8_basic();
    PRESCALE = PW'(8);
    run_frame("p8_basic", 8, 1, 32'h0, -1, -1);
  endtask

  task automatic test_glitch();
    PRESCALE = PW'(16);
    run_frame("p16_glitch", 16, 1, 32'h0, 0, 8);
  endtask

  task automatic test_p32_frame();
    PRESCALE = PW'(32);
    run_frame("p32_frame", 32, 11, 32'b010_1010_1010, -1, -1);
  endtask

  task automatic test_illegal_prescale();
    PRESCALE = PW'(12);
    run_frame("presc12", 8, 2, 32'b10, -1, -1);
  endtask

  task automatic test_reset_mid_frame();
    PRESCALE = PW'(8);
    for (int i = 0; i < 29; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (edge_cnt !== PW'(5) || bit_cnt !== BW'(3) || sample_data !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid precondition: got %0d/%0d/%b expected 5/3/0", edge_cnt, bit_cnt, sample_data);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_reset_values("rst_mid");
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_cnt_drop_vote();
    logic expv;
    PRESCALE = PW'(8);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(1'b0);
    for (int e = 0; e < 6; e++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (edge_cnt !== PW'(6) || sample_data !== 1'b1) begin
      errors++;
      $display("FAIL cnt_drop precondition: got %0d/%b expected 6/1", edge_cnt, sample_data);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL cnt_drop sample_valid: got %b expected 1", sample_valid);
      sb.delete();
    end else begin
      expv = sb.pop_front();
      checks++;
      if (sample_data !== expv) begin
        errors++;
        $display("FAIL cnt_drop sample_data: got %b expected %b", sample_data, expv);
      end
    end
    checks++;
    if (edge_cnt !== '0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_drop counters: got %0d/%0d expected 0/0", edge_cnt, bit_cnt);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sample_valid !== 1'b0 || sample_data !== 1'b0) begin
      errors++;
      $display("FAIL cnt_drop hold: got valid %b data %b expected 0/0", sample_valid, sample_data);
    end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; cnt_en = 1'b0; samp_en = 1'b0; PRESCALE = PW'(8);
    test_reset();
    test_p8_basic();
    test_glitch();
    test_p32_frame();
    test_illegal_prescale();
    test_reset_mid_frame();
    test_cnt_drop_vote();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
